mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
//
// PURPOSE
//   Initiator side of the data_memory interface (address / write_data / memwrite -> data_out).
//   Accepts one load or store request at a time from the CPU datapath over a valid/ready handshake.
//   Drives the memory port for a fixed number of settle cycles, then returns a response over a second valid/ready handshake.
//   Sits between the processor's execute stage and data_memory.
//
// PARAMETERS
//   ADDR_W  8  address width; must match data_memory
//   DATA_W  8  data width; must match data_memory
//   RD_LAT  2  cycles the memory port is held for a read before data_out is sampled (>=1)
//   WR_LAT  1  cycles mem_memwrite is held high for a store (>=1)
//
// PORTS
//   clk             in   1       rising-edge clock
//   reset           in   1       asynchronous reset, active-high
//   req_valid       in   1       request present
//   req_ready       out  1       controller can accept a request
//   req_write       in   1       1 = store, 0 = load
//   req_addr        in   ADDR_W  request address
//   req_wdata       in   DATA_W  store data; ignored for loads
//   rsp_valid       out  1       response present
//   rsp_ready       in   1       consumer takes the response
//   rsp_rdata       out  DATA_W  load data; 0 for stores
//   rsp_write       out  1       echo of req_write for this response
//   busy            out  1       high in ACCESS or RESP
//   mem_address     out  ADDR_W  to data_memory.address
//   mem_write_data  out  DATA_W  to data_memory.write_data
//   mem_memwrite    out  1       to data_memory.memwrite
//   mem_data_out    in   DATA_W  from data_memory.data_out
//
// BEHAVIOUR
//   - FSM states: IDLE, ACCESS, RESP. Reset drives state to IDLE.
//   - Reset values: rsp_valid=0, rsp_rdata=0, rsp_write=0, busy=0, mem_address=0, mem_write_data=0, mem_memwrite=0.
//   - req_ready = (state==IDLE) & ~reset. It is combinational and never high in ACCESS or RESP.
//   - IDLE: on req_valid & req_ready at edge N:
//       - register addr, wdata and write;
//       - load the down-counter with (write ? WR_LAT : RD_LAT) - 1;
//       - go to ACCESS.
//   - ACCESS (cycles N+1 .. N+LAT):
//       - mem_address = latched addr.
//       - mem_write_data = latched wdata for stores, 0 for loads.
//       - mem_memwrite = 1 only for stores, for exactly WR_LAT cycles.
//       - The counter decrements each cycle. At count==0:
//           - load: capture mem_data_out into rsp_rdata;
//           - store: set rsp_rdata to 0;
//           - then go to RESP.
//   - RESP: rsp_valid=1, with rsp_rdata and rsp_write stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE.
//   - Latency: rsp_valid is first high in cycle N+LAT+1. Minimum issue interval is LAT+2 cycles.
//   - mem_address holds its last value in IDLE/RESP; mem_memwrite is 0 outside store ACCESS cycles.
//   - Counter width is $clog2(max(RD_LAT,WR_LAT)+1). There is no address arithmetic; 8'hFF is a normal address.
//   - req_valid during ACCESS/RESP is ignored, and the requester must hold it.
//   - rsp_ready while rsp_valid=0 has no effect.
//   - Reset mid-operation: mem_memwrite and rsp_valid drop immediately (async), the in-flight request is discarded and no response is produced.
//
// TESTING
//   1. Reset, then read 0x00 (RD_LAT=2) -> req_ready=0 for 3 cycles; rsp_valid 3 cycles after accept, rsp_rdata=0x00, rsp_write=0, mem_memwrite never 1.
//   2. Store 0x24 <= 0xE6, then load 0x24 -> mem_memwrite high exactly 1 cycle with mem_address=0x24/mem_write_data=0xE6; the load returns 0xE6.
//   3. Store 0xFE <= 0x0F, store 0xFF <= 0x55, load both -> 0x0F and 0x55 (top-of-range addresses).
//   4. Load 0x35 with rsp_ready low for 5 cycles -> rsp_valid held, rsp_rdata stable, req_ready=0; a second req_valid is not accepted until 1 cycle after the handshake.
//   5. Assert reset in the first ACCESS cycle of store 0x10 <= 0xAA -> mem_memwrite falls with reset, no rsp_valid; a later load of 0x10 returns the old value.
//   6. Re-run 2 with RD_LAT=4, WR_LAT=3 -> mem_memwrite high 3 cycles; load response 5 cycles after accept.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for data_memory: one request at a time,
// fixed settle cycles on the memory port, then a held response.
module mem_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memwrite,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int MAXL = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CW = $clog2(MAXL + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic write_q;
  logic accept;
  logic done;

  assign accept = req_valid & req_ready;
  assign done = (state_q == ACCESS) && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = ACCESS;
      ACCESS: if (cnt_q == '0) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the strobes so they fall with reset, not at the next edge.
  assign req_ready = (state_q == IDLE) & ~reset;
  assign rsp_valid = (state_q == RESP) & ~reset;
  assign busy = (state_q != IDLE);
  assign mem_memwrite = (state_q == ACCESS) & write_q & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      write_q <= 1'b0;
      mem_address <= '0;
      mem_write_data <= '0;
      rsp_rdata <= '0;
      rsp_write <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        mem_address <= req_addr;
        mem_write_data <= req_write ? req_wdata : '0;
        cnt_q <= req_write ? CW'(WR_LAT - 1) : CW'(RD_LAT - 1);
      end else if (state_q == ACCESS && !done) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (done) begin
        rsp_rdata <= write_q ? '0 : mem_data_out;
        rsp_write <= write_q;
      end
    end
  end

endmodule
